bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised multi-digit synchronous BCD counter. It is the successor to our single-decade counter, with a configurable digit count, parallel load, an optional down-count mode and a cascade carry for chaining instances. It sits in the timing/display path, driving 7-segment decoders and event timers, and chains with further instances for wider counts.

## Interface
Parameters:
- DIGITS, 4: number of BCD decades; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  count-enable / cascade carry-in.
- load  in  1  synchronous parallel load strobe.
- load_val  in  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- up_dn  in  1  1 = count up, 0 = count down. Present only with BCD_CNT_DOWN_EN.
- Q  out  4*DIGITS  registered BCD count; digit 0 in bits [3:0].
- done  out  1  terminal count indicator.
- carry_out  out  1  wrap strobe for cascading.
- load_err  out  1  registered flag for a rejected load.

## Operation
- Priority per clk edge: reset_n low > load > enable > hold.
- Reset (asynchronous, immediate on reset_n falling):
  - Q = 0 on all digits.
  - load_err = 0.
- Load:
  - If every digit of load_val is ≤ 9: Q <= load_val and load_err <= 0.
  - If any digit is > 9: Q holds its value, load_err <= 1, and the whole load is ignored.
  - load overrides enable in the same cycle. carry_out is 0 during a load.
- Count up (enable = 1, load = 0):
  - Digit 0 increments.
  - Digit k increments only when all lower digits are 9. The digits that were 9 wrap to 0.
  - All-9s → all-0s.
- Count down (BCD_CNT_DOWN_EN with up_dn = 0):
  - Digit 0 decrements.
  - Digit k decrements only when all lower digits are 0. The digits that were 0 wrap to 9.
  - All-0s → all-9s.
- load_err:
  - Updates only on load cycles.
  - Otherwise it holds, so it is sticky until the next valid load or reset.
- done (combinational from Q):
  - 1 when Q is all-9s in up mode.
  - 1 when Q is all-0s in down mode.
- carry_out = done & enable & ~load. It is combinational and asserts in the cycle before the wrap edge.
- Cascading: connect carry_out of the lower instance to enable of the upper instance. This makes the chain behave as one wider counter with no added latency.
- Arithmetic:
  - Each digit is a 4-bit value in 0..9.
  - No binary intermediate wider than 4 bits per digit.
  - Codes 10..15 never appear on Q.
- Changing up_dn mid-count takes effect on the next enabled edge. There is no glitch on Q.

## Timing
- Q: one-cycle latency from enable or load to the updated value.
- load_err: one-cycle latency from a load cycle.
- done and carry_out: same cycle as Q and enable; combinational, with no register stage.
- Reset mid-count: Q goes to 0 asynchronously. The first count after reset_n rises happens on the first clk edge with enable = 1.
- Reset values:
  - Q = 0.
  - load_err = 0.
  - done = 0 in up mode; 1 in down mode, since Q = 0.
  - carry_out = done & enable.

## Configuration
- BCD_CNT_DOWN_EN defined:
  - The up_dn port exists.
  - Down counting and down-mode done/carry_out behave as above.
- BCD_CNT_DOWN_EN undefined:
  - The up_dn port is absent.
  - The counter is up-only.
  - done = Q all-9s.
  - The borrow logic is not synthesised.

## Structure
- Package bcd_pkg holds:
  - bcd_digit_t (4-bit digit type).
  - BCD_MAX = 4'd9 and BCD_MIN = 4'd0.
  - DIGITS_MAX = 8.
  - A function that validates a digit (≤ 9).
- Sub-module bcd_digit: one decade register.
  - Inputs: en, up, ld, ld_val.
  - Outputs: q, tc (terminal digit: 9 up, 0 down).
- bcd_counter_n instantiates DIGITS copies with a generate loop. It builds the ripple enable chain as en[k] = enable & tc of all lower digits, and does the load validation at top level.

## Test plan
- Reset and up-count, DIGITS = 2: reset_n low then high, enable = 1 for 100 cycles → Q goes 00, 01 … 99, 00; done = 1 only at 99; carry_out = 1 exactly once, at Q = 99.
- Wrap with load, DIGITS = 4: load 9998, then enable 3 cycles → Q = 9999 (done = 1, carry_out = 1), then 0000, then 0001.
- Invalid load: Q = 0042, load_val = 0x00A5 → Q stays 0042 and load_err = 1; a following load of 0x0123 → Q = 0123 and load_err = 0.
- Load priority: load = 1 with enable = 1 and load_val = 0500 while Q = 0999 → Q = 0500 next cycle, carry_out = 0.
- Down count with BCD_CNT_DOWN_EN: load 0100, up_dn = 0, enable 2 cycles → 0099, 0098. Then from 0000 → 9999, with carry_out = 1 in the 0000 cycle.
- Async reset mid-count: assert reset_n between clock edges at Q = 0357 → Q = 0000 immediately, before the next edge; counting resumes from 0001 on the first enabled edge after release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the multi-digit BCD counter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   bcd_digit_t      4-bit BCD decade value
//   BCD_MAX/BCD_MIN  terminal digit values for up/down counting
//   DIGITS_MAX       largest supported decade count per instance
//   bcd_digit_valid  returns 1 when a nibble is a legal BCD digit (0..9)
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX    = 4'd9;
   localparam bcd_digit_t BCD_MIN    = 4'd0;
   localparam int         DIGITS_MAX = 8;

   // Codes 10..15 are not BCD; used to reject a parallel load.
   function automatic logic bcd_digit_valid(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// One BCD decade register with load, count and terminal-digit flag.
// Latency: q updates one clk after en/ld; tc is combinational from q.
// Backpressure: none; en acts as the carry-in from the lower decade.
//
// Optional feature macro: BCD_CNT_DOWN_EN (adds the up input and borrow path).
// Ports:
//   clk, reset_n  rising-edge clock, asynchronous active-low reset
//   en            count this decade on the next edge
//   up            1 = increment, 0 = decrement (BCD_CNT_DOWN_EN only)
//   ld, ld_val    synchronous load of an already-validated digit
//   q             registered digit value, always 0..9
//   tc            digit is at its terminal value (9 up, 0 down)
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
`ifdef BCD_CNT_DOWN_EN
   input  logic       up,
`endif
   input  logic       ld,
   input  bcd_digit_t ld_val,
   output bcd_digit_t q,
   output logic       tc
);

   bcd_digit_t q_d;
   bcd_digit_t q_q;

   // Each decade works only on its own 4 bits: wrap is decided by comparing
   // against the terminal value rather than by a wider binary add.
   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = ld_val;
      end else if (en) begin
`ifdef BCD_CNT_DOWN_EN
         if (up) begin
            q_d = (q_q == BCD_MAX) ? BCD_MIN : (q_q + 4'd1);
         end else begin
            q_d = (q_q == BCD_MIN) ? BCD_MAX : (q_q - 4'd1);
         end
`else
         q_d = (q_q == BCD_MAX) ? BCD_MIN : (q_q + 4'd1);
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= BCD_MIN;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

   // Terminal digit follows the current direction so a mid-count change of
   // up drives the ripple chain correctly on the very next enabled edge.
`ifdef BCD_CNT_DOWN_EN
   assign tc = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);
`else
   assign tc = (q_q == BCD_MAX);
`endif

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// Parametrised DIGITS-decade synchronous BCD counter with load and cascade carry.
// Latency: Q/load_err one clk after enable/load; done/carry_out combinational.
// Backpressure: none; enable is the cascade carry-in, carry_out feeds the next stage.
//
// Optional feature macro: BCD_CNT_DOWN_EN (adds up_dn port and down counting).
// Parameters:
//   DIGITS     number of decades, 1..DIGITS_MAX
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (Q = 0, load_err = 0)
//   enable     count enable / cascade carry-in
//   load       synchronous parallel load strobe, wins over enable
//   load_val   BCD load value, digit 0 in [3:0]
//   up_dn      1 = up, 0 = down (BCD_CNT_DOWN_EN only)
//   Q          registered BCD count, digit 0 in [3:0]
//   done       terminal count (all 9s up, all 0s down)
//   carry_out  done & enable & ~load, asserted the cycle before the wrap
//   load_err   sticky flag: last load carried a non-BCD digit
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
`ifdef BCD_CNT_DOWN_EN
   input  logic                up_dn,
`endif
   output logic [4*DIGITS-1:0] Q,
   output logic                done,
   output logic                carry_out,
   output logic                load_err
);

   // ---------------------------------------------------------------------
   // Load validation: a single bad nibble rejects the whole word so Q never
   // holds a mix of old and new digits.
   // ---------------------------------------------------------------------
   logic load_ok;
   logic load_acc;

   always_comb begin
      load_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (!bcd_digit_valid(load_val[4*k +: 4])) begin
            load_ok = 1'b0;
         end
      end
   end

   assign load_acc = load & load_ok;

   // load_err only moves on load cycles; otherwise it is sticky.
   logic load_err_d;
   logic load_err_q;

   always_comb begin
      load_err_d = load_err_q;
      if (load) begin
         load_err_d = ~load_ok;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= load_err_d;
      end
   end

   assign load_err = load_err_q;

   // ---------------------------------------------------------------------
   // Decade array with ripple enable chain.
   // en_chain[k] = enable & ~load & tc of every lower digit. Gating with
   // ~load at the bottom keeps a rejected load from letting the count move.
   // The chain's top bit is exactly the cascade carry.
   // ---------------------------------------------------------------------
   logic [DIGITS:0]   en_chain;
   logic [DIGITS-1:0] tc;

   assign en_chain[0] = enable & ~load;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (en_chain[k]),
`ifdef BCD_CNT_DOWN_EN
         .up      (up_dn),
`endif
         .ld      (load_acc),
         .ld_val  (load_val[4*k +: 4]),
         .q       (Q[4*k +: 4]),
         .tc      (tc[k])
      );

      assign en_chain[k+1] = en_chain[k] & tc[k];
   end

   assign done      = &tc;
   assign carry_out = en_chain[DIGITS];

endmodule : bcd_counter_n

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

   localparam int          DIGITS = 4;
   localparam int          W      = 4 * DIGITS;
   localparam int unsigned MOD    = 10 ** DIGITS;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         enable;
   logic         load;
   logic [W-1:0] load_val;
`ifdef BCD_CNT_DOWN_EN
   logic         up_dn;
`endif
   logic [W-1:0] Q;
   logic         done;
   logic         carry_out;
   logic         load_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic run_cmp = 1'b0;

   bcd_counter_n #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .load      (load),
      .load_val  (load_val),
`ifdef BCD_CNT_DOWN_EN
      .up_dn     (up_dn),
`endif
      .Q         (Q),
      .done      (done),
      .carry_out (carry_out),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model: count as a plain integer ----------
   int unsigned m;
   logic        m_err;

   function automatic logic [W-1:0] to_bcd(input int unsigned v);
      logic [W-1:0] r;
      int unsigned  t;
      r = '0;
      t = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic bcd_ok(input logic [W-1:0] v);
      for (int k = 0; k < DIGITS; k++)
         if (v[4*k +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int unsigned from_bcd(input logic [W-1:0] v);
      int unsigned s;
      int unsigned p;
      s = 0;
      p = 1;
      for (int k = 0; k < DIGITS; k++) begin
         s = s + int'(v[4*k +: 4]) * p;
         p = p * 10;
      end
      return s;
   endfunction

   function automatic logic model_up();
`ifdef BCD_CNT_DOWN_EN
      return up_dn;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic model_done();
      return model_up() ? (m == MOD - 1) : (m == 0);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m     = 0;
         m_err = 1'b0;
      end else if (load) begin
         if (bcd_ok(load_val)) begin
            m     = from_bcd(load_val);
            m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end else if (enable) begin
         if (model_up()) m = (m + 1) % MOD;
         else            m = (m + MOD - 1) % MOD;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (run_cmp) begin
         chk("model_q",        64'(Q),         64'(to_bcd(m)));
         chk("model_done",     64'(done),      64'(model_done()));
         chk("model_carry",    64'(carry_out), 64'(model_done() & enable & ~load));
         chk("model_load_err", 64'(load_err),  64'(m_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic en, input logic ld, input logic [W-1:0] lv);
      enable   = en;
      load     = ld;
      load_val = lv;
   endtask

   // One clock with the current inputs; returns 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rnd;
   logic [W-1:0] lv_r;

   initial begin
      reset_n  = 1'b1;
      enable   = 1'b0;
      load     = 1'b0;
      load_val = '0;
`ifdef BCD_CNT_DOWN_EN
      up_dn    = 1'b1;
`endif
      #2 reset_n = 1'b0;
      #1 run_cmp = 1'b1;

      // Reset state (up mode): Q = 0, load_err = 0, done = 0
      #9;
      chk("reset_q",        64'(Q),        64'h0);
      chk("reset_load_err", 64'(load_err), 64'h0);
      chk("reset_done",     64'(done),     64'h0);
      tick();
      reset_n = 1'b1;

      // Plain up count from 0: 100 enables lands on 0100, no carry seen.
      set_in(1'b1, 1'b0, '0);
      repeat (100) tick();
      chk("count100_q", 64'(Q), 64'h0100);

      // Wrap via load 9998
      set_in(1'b0, 1'b1, 16'h9998);
      tick();
      chk("load9998_q", 64'(Q), 64'h9998);
      set_in(1'b1, 1'b0, '0);
      tick();
      chk("wrap_q9999",  64'(Q),         64'h9999);
      chk("wrap_done",   64'(done),      64'h1);
      chk("wrap_carry",  64'(carry_out), 64'h1);
      tick();
      chk("wrap_q0000",  64'(Q),         64'h0000);
      chk("wrap_carry0", 64'(carry_out), 64'h0);
      tick();
      chk("wrap_q0001",  64'(Q),         64'h0001);

      // Invalid load rejected, error sticky, next valid load clears it
      set_in(1'b0, 1'b1, 16'h0042);
      tick();
      set_in(1'b1, 1'b1, 16'h00A5);
      tick();
      chk("badload_q",   64'(Q),        64'h0042);
      chk("badload_err", 64'(load_err), 64'h1);
      set_in(1'b0, 1'b0, '0);
      tick();
      chk("badload_sticky", 64'(load_err), 64'h1);
      set_in(1'b0, 1'b1, 16'h0123);
      tick();
      chk("goodload_q",   64'(Q),        64'h0123);
      chk("goodload_err", 64'(load_err), 64'h0);

      // Load beats enable; carry suppressed during load
      set_in(1'b0, 1'b1, 16'h0999);
      tick();
      set_in(1'b1, 1'b1, 16'h0500);
      #1 chk("ldprio_carry", 64'(carry_out), 64'h0);
      tick();
      chk("ldprio_q", 64'(Q), 64'h0500);

      // Async reset mid-count at 0357
      set_in(1'b0, 1'b1, 16'h0350);
      tick();
      set_in(1'b1, 1'b0, '0);
      repeat (7) tick();
      chk("pre_reset_q", 64'(Q), 64'h0357);
      #1 reset_n = 1'b0;
      #1 chk("async_reset_q", 64'(Q), 64'h0000);
      tick();
      chk("held_reset_q", 64'(Q), 64'h0000);
      #2 reset_n = 1'b1;
      tick();
      chk("after_reset_q", 64'(Q), 64'h0001);

`ifdef BCD_CNT_DOWN_EN
      // Down count and 0000 -> 9999 wrap
      set_in(1'b0, 1'b1, 16'h0100);
      tick();
      up_dn = 1'b0;
      set_in(1'b1, 1'b0, '0);
      tick();
      chk("down_q0099", 64'(Q), 64'h0099);
      tick();
      chk("down_q0098", 64'(Q), 64'h0098);
      set_in(1'b0, 1'b1, 16'h0000);
      tick();
      set_in(1'b1, 1'b0, '0);
      #1;
      chk("down_done",  64'(done),      64'h1);
      chk("down_carry", 64'(carry_out), 64'h1);
      tick();
      chk("down_wrap_q", 64'(Q), 64'h9999);
      up_dn = 1'b1;
`endif

      // Randomised phase checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         rnd = $urandom;
         case ($urandom_range(0, 2))
            0:       lv_r = rnd[W-1:0];
            1:       lv_r = to_bcd($urandom % MOD);
            default: lv_r = (rnd[0]) ? to_bcd(MOD - 1 - $urandom_range(0, 3))
                                     : to_bcd($urandom_range(0, 3));
         endcase
         set_in($urandom_range(0, 99) < 70, $urandom_range(0, 9) == 0, lv_r);
`ifdef BCD_CNT_DOWN_EN
         if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
`endif
         if ($urandom_range(0, 199) == 0) begin
            #1 reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         tick();
      end

      run_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bcd_counter_n
